// File: rtl/cpu_pkg.sv
// Shared definitions for the UART-commanded mini processor: command encodings,
// response bytes and the packet assembler state type.
package cpu_pkg;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_ADD   = 2'b10;
    localparam logic [7:0] ACK       = 8'hAA;
    localparam logic [7:0] NAK       = 8'hEE;

    typedef enum logic [2:0] {
        ST_OPC, ST_D0, ST_D1, ST_D2, ST_D3, ST_EXEC, ST_RESP
    } asm_state_t;

    function automatic logic [31:0] byte_adr(input logic [5:0] word_addr);
        return {24'h000000, word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART engines: oversampling-free receiver that samples mid-bit, and a
// transmitter that can accept the next byte on the last stop-bit clock (no gap).
module uart_8n1 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    // Receiver: synchronize, detect start edge, confirm at half bit, then sample mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_sync, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_data  <= rx_sh;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign tx_ready = !tx_busy || (tx_cnt == CNT_LAST && tx_bit == 4'd9);

    // Transmitter: tx_bit counts bit slots already started (0 = start, 9 = stop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= 4'd0;
            tx_sh   <= 9'h1FF;
        end else if (tx_start && tx_ready) begin
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= 4'd0;
            tx_sh   <= {1'b1, tx_data};
        end else if (tx_busy) begin
            if (tx_cnt == CNT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx     <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cpu_top.sv
// UART-commanded mini processor: assembles command packets, executes them on a
// 32-bit word memory, replies over the UART and exposes the memory write port.
module uart_cpu_top
    import cpu_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    asm_state_t  state;
    logic [1:0]  cmd_r;
    logic [5:0]  addr_r;
    logic [31:0] word_r;
    logic [31:0] resp_r;
    logic [2:0]  tx_left;
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_word, exec_data;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr, tx_ready, tx_busy, tx_start;

    uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .rst_n    (reset),
        .rx       (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_data  (resp_r[7:0]),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx       (uart_tx)
    );

    assign tx_start = (state == ST_RESP) && (tx_left != 3'd0);

    // Memory read and the value a WRITE/ADD stores.
    always_comb begin
        rd_word = mem[addr_r];
        if (cmd_r == CMD_ADD) exec_data = rd_word + word_r;
        else                  exec_data = word_r;
    end

    // Data memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state == ST_EXEC && (cmd_r == CMD_WRITE || cmd_r == CMD_ADD))
            mem[addr_r] <= exec_data;
    end

    // Packet assembler, executor and response sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_OPC;
            cmd_r     <= 2'b00;
            addr_r    <= 6'd0;
            word_r    <= 32'h0;
            resp_r    <= 32'h0;
            tx_left   <= 3'd0;
            memwrite  <= 1'b0;
            writedata <= 32'h0;
            dataadr   <= 32'h0;
        end else begin
            memwrite <= 1'b0;
            case (state)
                ST_OPC: if (rx_valid) begin
                    cmd_r  <= rx_data[7:6];
                    addr_r <= rx_data[5:0];
                    word_r <= 32'h0;
                    state  <= (rx_data[7:6] == CMD_READ || rx_data[7:6] == 2'b11) ? ST_EXEC : ST_D0;
                end
                ST_D0: if (rx_ferr) state <= ST_OPC;
                       else if (rx_valid) begin word_r[7:0]   <= rx_data; state <= ST_D1; end
                ST_D1: if (rx_ferr) state <= ST_OPC;
                       else if (rx_valid) begin word_r[15:8]  <= rx_data; state <= ST_D2; end
                ST_D2: if (rx_ferr) state <= ST_OPC;
                       else if (rx_valid) begin word_r[23:16] <= rx_data; state <= ST_D3; end
                ST_D3: if (rx_ferr) state <= ST_OPC;
                       else if (rx_valid) begin word_r[31:24] <= rx_data; state <= ST_EXEC; end
                ST_EXEC: begin
                    state <= ST_RESP;
                    case (cmd_r)
                        CMD_WRITE, CMD_ADD: begin
                            memwrite  <= 1'b1;
                            writedata <= exec_data;
                            dataadr   <= byte_adr(addr_r);
                            resp_r    <= {24'h000000, ACK};
                            tx_left   <= 3'd1;
                        end
                        CMD_READ: begin
                            resp_r  <= rd_word;
                            tx_left <= 3'd4;
                        end
                        default: begin
                            resp_r  <= {24'h000000, NAK};
                            tx_left <= 3'd1;
                        end
                    endcase
                end
                // Wait for the final stop bit to leave the line before accepting a new opcode.
                ST_RESP: begin
                    if (tx_left == 3'd0) begin
                        if (!tx_busy) state <= ST_OPC;
                    end else if (tx_ready) begin
                        resp_r  <= {8'h00, resp_r[31:8]};
                        tx_left <= tx_left - 3'd1;
                    end
                end
                default: state <= ST_OPC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cpu_top.sv
// Scoreboard bench for uart_cpu_top: stimulus pushes expected TX bytes and memory
// writes; independent monitors decode uart_tx and memwrite and compare.
module tb_uart_cpu_top;
    localparam int CPB = 16;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx, memwrite;
    logic [31:0] writedata, dataadr;

    int   checks = 0;
    int   failures = 0;
    int   rst_epoch = 0;
    logic [7:0] exp_tx [$];
    wr_t        exp_wr [$];

    always #5 clk = ~clk;

    uart_cpu_top #(.CLK_HZ(1600), .BAUD(100), .MEM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int nstop, input logic stopval);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stopval;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat ((nstop - 1) * CPB) @(posedge clk);
    endtask

    task automatic send_pkt5(input logic [7:0] opc, input logic [31:0] w);
        send_byte(opc, 2, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 2, 1'b1);
    endtask

    task automatic push_word_tx(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_tx.size() != 0 && n < 60 * CPB * 10) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_tx.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_tx.size());
            exp_tx.delete();
        end
        repeat (2 * CPB) @(posedge clk);
    endtask

    initial forever begin
        @(negedge reset);
        rst_epoch++;
    end

    // TX monitor: decode frames at mid-bit and compare against the expected queue.
    initial begin : tx_mon
        logic [7:0] got, e;
        logic       sb, eb;
        int         ep;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB / 2) @(negedge clk);
                sb = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                eb = uart_tx;
                if (ep == rst_epoch) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        failures++;
                        $display("FAIL tx_unexpected got=%h exp=none", got);
                    end else begin
                        e = exp_tx.pop_front();
                        if (got !== e || sb !== 1'b0 || eb !== 1'b1) begin
                            failures++;
                            $display("FAIL tx_byte got=%h start=%b stop=%b exp=%h start=0 stop=1", got, sb, eb, e);
                        end
                    end
                end
            end
        end
    end

    // Memory-write monitor: every memwrite cycle must match the next expected write.
    initial begin : wr_mon
        wr_t w;
        forever begin
            @(negedge clk);
            if (memwrite === 1'b1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL memwrite_unexpected got adr=%h data=%h exp=none", dataadr, writedata);
                end else begin
                    w = exp_wr.pop_front();
                    if (dataadr !== w.adr || writedata !== w.data) begin
                        failures++;
                        $display("FAIL memwrite got adr=%h data=%h exp adr=%h data=%h",
                                 dataadr, writedata, w.adr, w.data);
                    end
                end
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_writedata", writedata, 32'h0);
        check("rst_dataadr", dataadr, 32'h0);
        check("rst_memwrite", {31'h0, memwrite}, 32'h0);
        reset = 1'b1;
        repeat (3 * CPB) @(posedge clk);

        exp_wr.push_back('{32'h0000_0000, 32'hFAFA_1313});
        exp_tx.push_back(8'hAA);
        send_pkt5(8'h00, 32'hFAFA_1313);
        wait_drain();

        push_word_tx(32'hFAFA_1313);
        send_byte(8'h40, 2, 1'b1);
        wait_drain();

        exp_wr.push_back('{32'h0000_0014, 32'h0000_0001});
        exp_tx.push_back(8'hAA);
        send_pkt5(8'h05, 32'h0000_0001);
        wait_drain();

        exp_wr.push_back('{32'h0000_0014, 32'h0000_0000});
        exp_tx.push_back(8'hAA);
        send_pkt5(8'h85, 32'hFFFF_FFFF);
        wait_drain();

        push_word_tx(32'h0000_0000);
        send_byte(8'h45, 2, 1'b1);
        wait_drain();

        exp_tx.push_back(8'hEE);
        send_byte(8'hC0, 2, 1'b1);
        wait_drain();

        // Framing error on the first operand byte aborts that packet.
        exp_wr.push_back('{32'h0000_000C, 32'h1234_5678});
        exp_tx.push_back(8'hAA);
        send_byte(8'h03, 2, 1'b1);
        send_byte(8'h11, 2, 1'b0);
        send_pkt5(8'h03, 32'h1234_5678);
        wait_drain();

        push_word_tx(32'h1234_5678);
        send_byte(8'h43, 2, 1'b1);
        repeat (15 * CPB) @(posedge clk);
        #3;
        reset = 1'b0;
        exp_tx.delete();
        exp_wr.delete();
        #1;
        check("midtx_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("midtx_writedata", writedata, 32'h0);
        check("midtx_dataadr", dataadr, 32'h0);
        check("midtx_memwrite", {31'h0, memwrite}, 32'h0);
        repeat (4) @(posedge clk);
        reset = 1'b1;
        repeat (6 * CPB) @(posedge clk);

        exp_wr.push_back('{32'h0000_001C, 32'hDEAD_BEEF});
        exp_tx.push_back(8'hAA);
        send_pkt5(8'h07, 32'hDEAD_BEEF);
        wait_drain();

        push_word_tx(32'hDEAD_BEEF);
        send_byte(8'h47, 2, 1'b1);
        wait_drain();

        check("exp_tx_left", exp_tx.size(), 32'h0);
        check("exp_wr_left", exp_wr.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
